trigger_network_controller: RTL and testbench
=============================================

# trigger_network_controller

Network-level scheduler for a group of per-actor trigger blocks. Accepts the network `ap_start` and fans a one-cycle start to every enabled actor trigger. Closes the sleep/sync barrier by reducing the triggers' `sleep`/`sync_wait`/`sync_exec` status into the shared `all_sleep`/`all_sync`/`all_sync_wait` inputs. Collects per-trigger `ap_done` into a single network `ap_done`, and counts barrier rounds and busy cycles for host profiling.

## Interface
- `NUM_ACTORS`, 4: number of trigger instances served; at least 1.
- `CNT_W`, 32: width of the profiling counters.
- `ap_clk`  in  1  clock; all state changes on its rising edge.
- `ap_rst_n`  in  1  reset, asynchronous, active-low.
- `ap_start`  in  1  network start request.
- `actor_enable`  in  NUM_ACTORS  per-actor participation mask; sampled only when a start is accepted.
- `trig_sleep`, `trig_sync_exec`, `trig_sync_wait`  in  NUM_ACTORS each  status outputs of each trigger.
- `trig_done`  in  NUM_ACTORS  per-trigger `ap_done`.
- `trig_start`  out  NUM_ACTORS  per-trigger `ap_start`.
- `all_sleep`, `all_sync`, `all_sync_wait`  out  1 each  barrier reductions, broadcast to every trigger.
- `ap_done`, `ap_ready`  out  1  network completion pulse; the two are identical.
- `ap_idle`  out  1  controller is in IDLE.
- `sync_rounds`  out  CNT_W  number of barriers that resumed execution in the current or last run.
- `busy_cycles`  out  CNT_W  cycles spent in START, RUN and DONE in the current or last run.

## Operation
- FSM states: IDLE, START, RUN, DONE.
  - IDLE: when `ap_start`=1, go to START. On that edge, latch `actor_enable` into `mask_q`, clear `done_seen`, clear both counters.
  - START: go to RUN if `mask_q`≠0, otherwise go to DONE.
  - RUN: go to DONE when `(done_seen | ~mask_q)` is all-ones. `done_seen` is the next-state value, so a done arriving this cycle counts.
  - DONE: go to IDLE unconditionally.
- `trig_start = mask_q` while in START, 0 in every other state. This is a single-cycle pulse; the triggers sample it from their idle state.
- `done_seen[i]` is a sticky bit, set in RUN when `trig_done[i]`=1. It is never cleared except on start acceptance or reset.
- Barrier reductions are combinational, with zero latency. This is mandatory: triggers leave the sync states on the cycle after `all_sync`, so a registered reduction would double-count barriers or stall.
  - `all_sleep = inRUN & AND_i(trig_sleep[i] | ~mask_q[i])`
  - `all_sync = inRUN & AND_i(trig_sync_exec[i] | trig_sync_wait[i] | ~mask_q[i])`
  - `all_sync_wait = inRUN & AND_i(trig_sync_wait[i] | ~mask_q[i])`
  - Disabled actors never block a barrier. All three reductions are 0 outside RUN.
- `sync_rounds` increments by 1 on each cycle of RUN where `all_sync`=1, `all_sync_wait`=0, and `all_sync_q`=0.
  - `all_sync_q` is `all_sync` registered. Counting on the rising edge protects against a multi-cycle `all_sync`.
  - The terminating barrier (`all_sync_wait`=1) is not counted.
- `busy_cycles` increments in START, RUN and DONE.
- Both counters saturate at all-ones and hold their value in IDLE until the next start.
- `ap_start` outside IDLE is ignored. No queueing.

## Timing
- Reset (async assert) values: state=IDLE, `ap_idle`=1, `trig_start`=0, `ap_done`=`ap_ready`=0, `all_*`=0, `mask_q`=0, `done_seen`=0, counters=0.
- Reset deasserted is synchronised by the integrating shell; inside this block reset clears asynchronously.
- Cycle-level sequence, with `ap_start` high in cycle 0 while in IDLE:
  - Cycle 1: START. `trig_start`=`mask_q`, `ap_idle`=0.
  - Cycle 2: RUN.
  - If the last enabled `trig_done` arrives in cycle k, DONE is cycle k+1 with `ap_done`=1 for exactly one cycle.
  - Cycle k+2: IDLE.
- With an empty mask, `ap_done` is asserted in cycle 2.
- `busy_cycles` at completion equals the number of non-IDLE cycles, including DONE.
- Simultaneous done from all triggers in one cycle is handled in that same cycle.
- Reset mid-RUN: outputs drop to reset values immediately. The triggers are reset by the same `ap_rst_n`.

## Test plan
- Reset then idle: `ap_rst_n`=0 during RUN, `NUM_ACTORS`=4 -> same cycle: `trig_start`=0, `ap_idle`=1, `all_sleep`=0, `sync_rounds`=0, `busy_cycles`=0.
- Start fan-out: `actor_enable`=4'b1111, `ap_start` pulse in cycle 0 -> `trig_start`=4'b1111 in cycle 1 only; a second `ap_start` in cycle 3 is ignored.
- Masked barrier: mask 4'b0101, `trig_sleep`=4'b0001 -> `all_sleep`=0; `trig_sleep`=4'b0101 -> `all_sleep`=1 in the same cycle; `trig_start`=4'b0101.
- Barrier counting: two barriers with mixed exec/wait, each `all_sync` held 2 cycles, then a barrier with all four in `trig_sync_wait` and `trig_done`=4'b1111 -> `all_sync_wait`=1, `sync_rounds`=2, `ap_done`=1 the next cycle.
- Staggered done: `trig_done` bits 0,1 in cycle 10 and bits 2,3 in cycle 14 -> `ap_done`=`ap_ready`=1 in cycle 15 only, `ap_idle`=1 in cycle 16.
- Empty mask: `actor_enable`=0, start in cycle 0 -> `trig_start`=0, `ap_done` in cycle 2, `busy_cycles`=2, `sync_rounds`=0.

Source files
------------

// File: rtl/trigger_network_controller.sv
// Network-level scheduler for a group of trigger blocks. It fans out a one-cycle
// start, closes the sleep/sync barriers combinationally, and merges per-actor done.
module trigger_network_controller #(
   parameter int NUM_ACTORS = 4,
   parameter int CNT_W      = 32
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  ap_start,
   input  logic [NUM_ACTORS-1:0] actor_enable,
   input  logic [NUM_ACTORS-1:0] trig_sleep,
   input  logic [NUM_ACTORS-1:0] trig_sync_exec,
   input  logic [NUM_ACTORS-1:0] trig_sync_wait,
   input  logic [NUM_ACTORS-1:0] trig_done,
   output logic [NUM_ACTORS-1:0] trig_start,
   output logic                  all_sleep,
   output logic                  all_sync,
   output logic                  all_sync_wait,
   output logic                  ap_done,
   output logic                  ap_ready,
   output logic                  ap_idle,
   output logic [CNT_W-1:0]      sync_rounds,
   output logic [CNT_W-1:0]      busy_cycles
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t                  state_reg, state_next;
   logic [NUM_ACTORS-1:0]   mask_reg;
   logic [NUM_ACTORS-1:0]   done_seen_reg, done_seen_next;
   logic                    all_sync_reg;
   logic [CNT_W-1:0]        sync_rounds_reg, busy_cycles_reg;
   logic                    in_run, accept, count_round;

   logic [NUM_ACTORS-1:0]   sleep_ok, sync_ok, wait_ok, done_ok;

   // A disabled actor is treated as permanently satisfying every barrier and done.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_ACTORS; gi++) begin : g_actor
         assign sleep_ok[gi] = trig_sleep[gi] | ~mask_reg[gi];
         assign sync_ok[gi]  = trig_sync_exec[gi] | trig_sync_wait[gi] | ~mask_reg[gi];
         assign wait_ok[gi]  = trig_sync_wait[gi] | ~mask_reg[gi];
         assign done_ok[gi]  = done_seen_next[gi] | ~mask_reg[gi];
      end
   endgenerate

   assign in_run        = (state_reg == ST_RUN);
   assign accept        = (state_reg == ST_IDLE) && ap_start;
   assign all_sleep     = in_run & (&sleep_ok);
   assign all_sync      = in_run & (&sync_ok);
   assign all_sync_wait = in_run & (&wait_ok);
   // Count only the first cycle of a resuming barrier; the terminating one is excluded.
   assign count_round   = all_sync & ~all_sync_wait & ~all_sync_reg;

   assign done_seen_next = done_seen_reg | (in_run ? trig_done : '0);

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE:  if (ap_start) state_next = ST_START;
         ST_START: state_next = (mask_reg != '0) ? ST_RUN : ST_DONE;
         ST_RUN:   if (&done_ok) state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_reg       <= ST_IDLE;
         mask_reg        <= '0;
         done_seen_reg   <= '0;
         all_sync_reg    <= 1'b0;
         sync_rounds_reg <= '0;
         busy_cycles_reg <= '0;
      end else begin
         state_reg    <= state_next;
         all_sync_reg <= all_sync;
         if (accept) begin
            mask_reg        <= actor_enable;
            done_seen_reg   <= '0;
            sync_rounds_reg <= '0;
            busy_cycles_reg <= '0;
         end else begin
            done_seen_reg <= done_seen_next;
            if (count_round && sync_rounds_reg != '1)
               sync_rounds_reg <= sync_rounds_reg + CNT_ONE;
            if (state_reg != ST_IDLE && busy_cycles_reg != '1)
               busy_cycles_reg <= busy_cycles_reg + CNT_ONE;
         end
      end
   end

   assign trig_start  = (state_reg == ST_START) ? mask_reg : '0;
   assign ap_done     = (state_reg == ST_DONE);
   assign ap_ready    = ap_done;
   assign ap_idle     = (state_reg == ST_IDLE);
   assign sync_rounds = sync_rounds_reg;
   assign busy_cycles = busy_cycles_reg;

endmodule

// File: tb/tb_trigger_network_controller.sv
// Directed bench for trigger_network_controller: fan-out, masked barriers,
// barrier counting, staggered done, empty mask and reset mid-run.
module tb_trigger_network_controller;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        ap_start;
   logic [3:0]  actor_enable, trig_sleep, trig_sync_exec, trig_sync_wait, trig_done;
   logic [3:0]  trig_start;
   logic        all_sleep, all_sync, all_sync_wait, ap_done, ap_ready, ap_idle;
   logic [31:0] sync_rounds, busy_cycles;

   int checks = 0;
   int errors = 0;

   always #5 ap_clk = ~ap_clk;

   trigger_network_controller #(.NUM_ACTORS(4), .CNT_W(32)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
      .actor_enable(actor_enable), .trig_sleep(trig_sleep),
      .trig_sync_exec(trig_sync_exec), .trig_sync_wait(trig_sync_wait),
      .trig_done(trig_done), .trig_start(trig_start), .all_sleep(all_sleep),
      .all_sync(all_sync), .all_sync_wait(all_sync_wait), .ap_done(ap_done),
      .ap_ready(ap_ready), .ap_idle(ap_idle), .sync_rounds(sync_rounds),
      .busy_cycles(busy_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Advance to just after the next rising edge; inputs are then driven, outputs checked 1 later.
   task automatic cyc();
      @(posedge ap_clk);
      #1;
   endtask

   initial begin
      ap_rst_n = 1'b0; ap_start = 1'b0; actor_enable = '0;
      trig_sleep = '0; trig_sync_exec = '0; trig_sync_wait = '0; trig_done = '0;
      #1;
      chk("rst_idle", {31'd0, ap_idle}, 32'd1);
      chk("rst_trig_start", {28'd0, trig_start}, 32'd0);
      chk("rst_done", {31'd0, ap_done}, 32'd0);
      cyc(); cyc();
      ap_rst_n = 1'b1;
      cyc();

      // Start fan-out, ignored second start, staggered done
      ap_start = 1'b1; actor_enable = 4'b1111;                    // cycle 0
      cyc(); ap_start = 1'b0; actor_enable = 4'b0000; #1;         // cycle 1
      chk("fan_trig_start_c1", {28'd0, trig_start}, 32'hF);
      chk("fan_idle_c1", {31'd0, ap_idle}, 32'd0);
      cyc(); #1;                                                  // cycle 2
      chk("fan_trig_start_c2", {28'd0, trig_start}, 32'h0);
      cyc(); ap_start = 1'b1;                                     // cycle 3
      cyc(); ap_start = 1'b0; #1;                                 // cycle 4
      chk("fan_ignored_start", {28'd0, trig_start}, 32'h0);
      repeat (6) cyc();                                           // cycle 10
      trig_done = 4'b0011;
      cyc(); trig_done = 4'b0000; #1;                             // cycle 11
      chk("stag_no_done_c11", {31'd0, ap_done}, 32'd0);
      repeat (3) cyc();                                           // cycle 14
      trig_done = 4'b1100; #1;
      chk("stag_no_done_c14", {31'd0, ap_done}, 32'd0);
      cyc(); trig_done = 4'b0000; #1;                             // cycle 15
      chk("stag_done_c15", {31'd0, ap_done}, 32'd1);
      chk("stag_ready_c15", {31'd0, ap_ready}, 32'd1);
      cyc(); #1;                                                  // cycle 16
      chk("stag_done_c16", {31'd0, ap_done}, 32'd0);
      chk("stag_idle_c16", {31'd0, ap_idle}, 32'd1);
      chk("stag_busy", busy_cycles, 32'd15);
      chk("stag_rounds", sync_rounds, 32'd0);
      cyc(); cyc(); #1;
      chk("stag_busy_hold", busy_cycles, 32'd15);

      // Masked barrier, then reset mid-RUN
      ap_start = 1'b1; actor_enable = 4'b0101;                    // cycle 0
      cyc(); ap_start = 1'b0; #1;                                 // cycle 1
      chk("mask_trig_start", {28'd0, trig_start}, 32'h5);
      cyc(); trig_sleep = 4'b0001; #1;                            // cycle 2
      chk("mask_sleep_partial", {31'd0, all_sleep}, 32'd0);
      cyc(); trig_sleep = 4'b0101; #1;                            // cycle 3
      chk("mask_sleep_full", {31'd0, all_sleep}, 32'd1);
      cyc(); #1;                                                  // cycle 4
      chk("mask_busy_pre_rst", busy_cycles, 32'd3);
      ap_rst_n = 1'b0; #1;
      chk("rst_run_trig_start", {28'd0, trig_start}, 32'd0);
      chk("rst_run_idle", {31'd0, ap_idle}, 32'd1);
      chk("rst_run_all_sleep", {31'd0, all_sleep}, 32'd0);
      chk("rst_run_rounds", sync_rounds, 32'd0);
      chk("rst_run_busy", busy_cycles, 32'd0);
      trig_sleep = '0;
      cyc(); ap_rst_n = 1'b1;
      cyc();

      // Barrier counting with multi-cycle all_sync and a terminating wait barrier
      ap_start = 1'b1; actor_enable = 4'b1111;                    // cycle 0
      cyc(); ap_start = 1'b0;                                     // cycle 1
      cyc();                                                      // cycle 2
      cyc(); trig_sync_exec = 4'b0011; trig_sync_wait = 4'b1100; #1; // cycle 3
      chk("bar1_all_sync", {31'd0, all_sync}, 32'd1);
      chk("bar1_all_wait", {31'd0, all_sync_wait}, 32'd0);
      cyc(); #1;                                                  // cycle 4
      chk("bar1_rounds_c4", sync_rounds, 32'd1);
      cyc(); trig_sync_exec = '0; trig_sync_wait = '0; #1;        // cycle 5
      chk("bar_gap_all_sync", {31'd0, all_sync}, 32'd0);
      chk("bar1_rounds_c5", sync_rounds, 32'd1);
      cyc(); trig_sync_exec = 4'b1010; trig_sync_wait = 4'b0101;  // cycle 6
      cyc();                                                      // cycle 7
      cyc(); trig_sync_exec = '0; trig_sync_wait = '0;            // cycle 8
      cyc(); trig_sync_wait = 4'b1111; trig_done = 4'b1111; #1;   // cycle 9
      chk("term_all_wait", {31'd0, all_sync_wait}, 32'd1);
      chk("term_rounds", sync_rounds, 32'd2);
      cyc(); trig_sync_wait = '0; trig_done = '0; #1;             // cycle 10
      chk("term_done", {31'd0, ap_done}, 32'd1);
      chk("term_all_wait_off", {31'd0, all_sync_wait}, 32'd0);
      cyc(); #1;                                                  // cycle 11
      chk("term_rounds_final", sync_rounds, 32'd2);
      chk("term_busy", busy_cycles, 32'd10);

      // Empty mask
      cyc();
      ap_start = 1'b1; actor_enable = 4'b0000;                    // cycle 0
      cyc(); ap_start = 1'b0; #1;                                 // cycle 1
      chk("empty_trig_start", {28'd0, trig_start}, 32'd0);
      chk("empty_idle_c1", {31'd0, ap_idle}, 32'd0);
      cyc(); #1;                                                  // cycle 2
      chk("empty_done_c2", {31'd0, ap_done}, 32'd1);
      cyc(); #1;                                                  // cycle 3
      chk("empty_idle_c3", {31'd0, ap_idle}, 32'd1);
      chk("empty_busy", busy_cycles, 32'd2);
      chk("empty_rounds", sync_rounds, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
